// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants and tag type for the decode-stage
// forwarding and hazard controller.
package fwd_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   localparam logic [1:0] TUSE_NONE = 2'd3;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LOAD = 2'd2;

   typedef struct packed {
      logic       valid;
      logic [4:0] wa;
      logic [1:0] tnew;
   } tag_t;

   // Advance a tag one stage: Tnew counts down, floor 0.
   function automatic tag_t age(input tag_t t);
      tag_t r;
      r = t;
      if (t.tnew != 2'd0)
         r.tnew = t.tnew - 2'd1;
      return r;
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_match.sv
// One source operand checked against the E/M/W tags,
// giving its forward select and a hazard flag.
module fwd_match
   import fwd_hazard_ctrl_pkg::*;
(
   input  logic [4:0] src,
   input  logic [1:0] tuse,
   input  tag_t       tag_e,
   input  tag_t       tag_m,
   input  tag_t       tag_w,
   output logic [1:0] sel,
   output logic       hazard
);

   logic       hit;
   logic [1:0] code;
   logic [1:0] tnew;

   // Youngest producer wins; $0 never matches.
   always_comb begin
      hit  = 1'b0;
      code = FWD_RF;
      tnew = 2'd0;
      if (src != 5'd0) begin
         if (tag_e.valid && tag_e.wa == src) begin
            hit  = 1'b1;
            code = FWD_E;
            tnew = tag_e.tnew;
         end else if (tag_m.valid && tag_m.wa == src) begin
            hit  = 1'b1;
            code = FWD_M;
            tnew = tag_m.tnew;
         end else if (tag_w.valid && tag_w.wa == src) begin
            hit  = 1'b1;
            code = FWD_W;
            tnew = tag_w.tnew;
         end
      end
   end

   assign sel    = (hit && tnew == 2'd0) ? code : FWD_RF;
   assign hazard = hit && (tuse != TUSE_NONE) && (tnew > tuse);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Tracks in-flight destinations and the MD busy counter;
// drives decode forward selects and the pipeline stall.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       d_valid,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [1:0] d_rs_tuse,
   input  logic [1:0] d_rt_tuse,
   input  logic [4:0] d_wa,
   input  logic [1:0] d_tnew,
   input  logic       d_md_use,
   input  logic       flush,
   input  logic       e_md_start,
   output logic       stall,
   output logic [1:0] rs_sel,
   output logic [1:0] rt_sel,
   output logic       md_busy
);

   tag_t       tag_e;
   tag_t       tag_m;
   tag_t       tag_w;
   tag_t       tag_d;
   logic [3:0] md_cnt;
   logic       hz_rs;
   logic       hz_rt;
   logic       md_hazard;

   assign tag_d.valid = d_valid;
   assign tag_d.wa    = d_wa;
   assign tag_d.tnew  = d_tnew;

   fwd_match u_rs (
      .src    (d_rs),
      .tuse   (d_rs_tuse),
      .tag_e  (tag_e),
      .tag_m  (tag_m),
      .tag_w  (tag_w),
      .sel    (rs_sel),
      .hazard (hz_rs)
   );

   fwd_match u_rt (
      .src    (d_rt),
      .tuse   (d_rt_tuse),
      .tag_e  (tag_e),
      .tag_m  (tag_m),
      .tag_w  (tag_w),
      .sel    (rt_sel),
      .hazard (hz_rt)
   );

   // A start in E this cycle already blocks MD consumers.
   assign md_hazard = d_md_use && (md_cnt != 4'd0 || e_md_start);
   assign stall     = d_valid && (hz_rs || hz_rt || md_hazard);
   assign md_busy   = (md_cnt != 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_e  <= '0;
         tag_m  <= '0;
         tag_w  <= '0;
         md_cnt <= 4'd0;
      end else begin
         tag_w <= age(tag_m);
         tag_m <= age(tag_e);
         if (stall || flush)
            tag_e <= '0;
         else
            tag_e <= tag_d;
         if (e_md_start)
            md_cnt <= 4'(MD_LAT);
         else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl.
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_valid;
   logic [4:0] d_rs, d_rt, d_wa;
   logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
   logic       d_md_use, flush, e_md_start;
   logic       stall, md_busy;
   logic [1:0] rs_sel, rt_sel;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.MD_LAT(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .d_valid    (d_valid),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_rs_tuse  (d_rs_tuse),
      .d_rt_tuse  (d_rt_tuse),
      .d_wa       (d_wa),
      .d_tnew     (d_tnew),
      .d_md_use   (d_md_use),
      .flush      (flush),
      .e_md_start (e_md_start),
      .stall      (stall),
      .rs_sel     (rs_sel),
      .rt_sel     (rt_sel),
      .md_busy    (md_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_d();
      d_valid = 0; d_rs = 0; d_rt = 0; d_wa = 0;
      d_rs_tuse = 3; d_rt_tuse = 3; d_tnew = 0;
      d_md_use = 0; flush = 0; e_md_start = 0;
   endtask

   task automatic drain();
      idle_d();
      repeat (4) step();
   endtask

   task automatic test_reset();
      reset = 1;
      idle_d();
      step(); step();
      reset = 0;
      d_valid = 1; d_rs = 5; d_rs_tuse = 1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || rs_sel !== 2'd0 || md_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: stall=%b rs_sel=%0d md_busy=%b want 0 0 0",
                  stall, rs_sel, md_busy);
      end
      drain();
   endtask

   task automatic test_alu_chain();
      idle_d();
      d_valid = 1; d_wa = 8; d_tnew = 1;
      step();
      idle_d();
      d_valid = 1; d_rs = 8; d_rs_tuse = 1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || rs_sel !== 2'd0) begin
         errors++;
         $display("FAIL alu_e: stall=%b rs_sel=%0d want 0 0", stall, rs_sel);
      end
      step();
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || rs_sel !== 2'd2) begin
         errors++;
         $display("FAIL alu_m: stall=%b rs_sel=%0d want 0 2", stall, rs_sel);
      end
      step();
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || rs_sel !== 2'd3) begin
         errors++;
         $display("FAIL alu_w: stall=%b rs_sel=%0d want 0 3", stall, rs_sel);
      end
      drain();
   endtask

   task automatic test_load_use();
      idle_d();
      d_valid = 1; d_wa = 9; d_tnew = 2;
      step();
      idle_d();
      d_valid = 1; d_rt = 9; d_rt_tuse = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (stall !== 1'b1 || rt_sel !== 2'd0) begin
            errors++;
            $display("FAIL load_stall%0d: stall=%b rt_sel=%0d want 1 0",
                     i, stall, rt_sel);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || rt_sel !== 2'd3) begin
         errors++;
         $display("FAIL load_release: stall=%b rt_sel=%0d want 0 3",
                  stall, rt_sel);
      end
      // The stalled consumer's bubbles must not hold a real tag.
      idle_d();
      d_valid = 1; d_wa = 0;
      step();
      @(negedge clk);
      checks++;
      if (rt_sel !== 2'd0) begin
         errors++;
         $display("FAIL load_drained: rt_sel=%0d want 0", rt_sel);
      end
      drain();
   endtask

   task automatic test_priority();
      idle_d();
      d_valid = 1; d_wa = 4; d_tnew = 0;
      step();
      step();
      idle_d();
      d_valid = 1; d_rs = 4; d_rs_tuse = 0;
      @(negedge clk);
      checks++;
      if (rs_sel !== 2'd1 || stall !== 1'b0) begin
         errors++;
         $display("FAIL prio_e: rs_sel=%0d stall=%b want 1 0", rs_sel, stall);
      end
      #1 d_rs = 0;
      #1;
      checks++;
      if (rs_sel !== 2'd0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL prio_r0: rs_sel=%0d stall=%b want 0 0", rs_sel, stall);
      end
      drain();
   endtask

   task automatic test_md();
      idle_d();
      d_valid = 1; d_md_use = 1; e_md_start = 1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || md_busy !== 1'b0) begin
         errors++;
         $display("FAIL md_start: stall=%b md_busy=%b want 1 0", stall, md_busy);
      end
      step();
      e_md_start = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (stall !== 1'b1 || md_busy !== 1'b1) begin
            errors++;
            $display("FAIL md_busy%0d: stall=%b md_busy=%b want 1 1",
                     i, stall, md_busy);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || md_busy !== 1'b0) begin
         errors++;
         $display("FAIL md_done: stall=%b md_busy=%b want 0 0", stall, md_busy);
      end
      idle_d();
      e_md_start = 1;
      step();
      e_md_start = 0;
      repeat (3) step();
      e_md_start = 1;
      step();
      e_md_start = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL md_reload%0d: md_busy=%b want 1", i, md_busy);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b0) begin
         errors++;
         $display("FAIL md_reload_end: md_busy=%b want 0", md_busy);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      idle_d();
      d_valid = 1; d_wa = 9; d_tnew = 2; e_md_start = 1;
      step();
      idle_d();
      d_valid = 1; d_rt = 9; d_rt_tuse = 0; d_rs = 9; d_rs_tuse = 0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || md_busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: stall=%b md_busy=%b want 1 1", stall, md_busy);
      end
      reset = 1;
      step();
      reset = 0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || rs_sel !== 2'd0 || rt_sel !== 2'd0 ||
          md_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: stall=%b rs=%0d rt=%0d busy=%b want 0 0 0 0",
                  stall, rs_sel, rt_sel, md_busy);
      end
      drain();
   endtask

   task automatic test_flush();
      idle_d();
      d_valid = 1; d_wa = 8; d_tnew = 1; flush = 1;
      step();
      idle_d();
      d_valid = 1; d_rs = 8; d_rs_tuse = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (rs_sel !== 2'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush%0d: rs_sel=%0d stall=%b want 0 0",
                     i, rs_sel, stall);
         end
         step();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_load_use();
      test_priority();
      test_md();
      test_reset_mid();
      test_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
